aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 97 +++++++++
 tb/tb_aes_round_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM that steps an iterative AES datapath through
// NR rounds of STEPS cycles each, with key-schedule strobes and a ready/valid handshake.
module aes_round_sequencer #(
   parameter int STEPS  = 3,
   parameter int STEP_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        key_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              load,
   output logic [3:0]        round_index,
   output logic [STEP_W-1:0] round_step,
   output logic              last_round,
   output logic              enable_ks,
   output logic              mode_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_FIN  = STEP_W'(STEPS - 2);

   logic [1:0]        state, state_n;
   logic [3:0]        rnd, rnd_n;
   logic [3:0]        nr, nr_n;
   logic [STEP_W-1:0] step, step_n;
   logic              err_n;
   logic              in_round, fin_round, fin_step, wrap;

   assign in_round  = state == ROUND;
   assign fin_round = in_round && rnd == nr - 4'd1;
   // the final round is one step short: the datapath drops MixColumns there
   assign fin_step  = fin_round && step == STEP_FIN;
   assign wrap      = in_round && step == STEP_LAST;

   assign in_ready    = !flush && (state == IDLE || (state == DONE && out_ready));
   assign load        = rst_n && in_valid && in_ready;
   assign out_valid   = !flush && state == DONE;
   assign round_index = in_round ? rnd : 4'd0;
   assign round_step  = in_round ? step : '0;
   assign last_round  = fin_round;
   assign enable_ks   = wrap || fin_step;

   always_comb begin
      state_n = state;
      rnd_n   = rnd;
      step_n  = step;
      nr_n    = nr;
      err_n   = mode_err;
      if (flush) begin
         state_n = IDLE;
         rnd_n   = 4'd0;
         step_n  = '0;
      end else if (load) begin
         state_n = ROUND;
         rnd_n   = 4'd0;
         step_n  = '0;
         nr_n    = key_mode == 2'd1 ? 4'd12 : key_mode == 2'd2 ? 4'd14 : 4'd10;
         err_n   = mode_err || key_mode == 2'd3;
      end else if (fin_step) begin
         state_n = DONE;
         rnd_n   = 4'd0;
         step_n  = '0;
      end else if (wrap) begin
         step_n = '0;
         rnd_n  = rnd + 4'd1;
      end else if (in_round) begin
         step_n = step + 1'b1;
      end else if (state == DONE && out_ready) begin
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rnd      <= 4'd0;
         step     <= '0;
         nr       <= 4'd10;
         mode_err <= 1'b0;
      end else begin
         state    <= state_n;
         rnd      <= rnd_n;
         step     <= step_n;
         nr       <= nr_n;
         mode_err <= err_n;
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench; each accepted block pushes its expected
// round profile, which is compared when the ciphertext handshake completes.
module tb_aes_round_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] key_mode = 2'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       load;
   logic [3:0] round_index;
   logic [1:0] round_step;
   logic       last_round;
   logic       enable_ks;
   logic       mode_err;

   typedef struct {
      int rc;
      int kc;
      int lc;
      int mi;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   rc = 0, kc = 0, lc = 0, mi = 0;

   aes_round_sequencer #(.STEPS(3), .STEP_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .key_mode(key_mode), .out_valid(out_valid), .out_ready(out_ready), .load(load),
      .round_index(round_index), .round_step(round_step), .last_round(last_round),
      .enable_ks(enable_ks), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic exp_t mk(input logic [1:0] m);
      exp_t e;
      int   nr;
      nr   = m == 2'd1 ? 12 : m == 2'd2 ? 14 : 10;
      e.rc = nr * 3 - 1;
      e.kc = nr;
      e.lc = 2;
      e.mi = nr - 1;
      return e;
   endfunction

   // per-block profile of ROUND cycles, scored on the completing handshake
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("round_cycles", rc, e.rc);
            chk("ks_pulses", kc, e.kc);
            chk("last_round_cycles", lc, e.lc);
            chk("max_round_index", mi, e.mi);
         end
      end
      if (load) begin
         rc = 0; kc = 0; lc = 0; mi = 0;
      end else if (rst_n && !flush && !in_ready && !out_valid) begin
         rc++;
         kc += int'(enable_ks);
         lc += int'(last_round);
         if (int'(round_index) > mi) mi = int'(round_index);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] m);
      in_valid = 1'b1;
      key_mode = m;
      q.push_back(mk(m));
      #1 chk("load_on_accept", load, 1);
      step();
      in_valid = 1'b0;
      key_mode = ~m;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && !out_valid; i++) step();
      if (!out_valid) chk("done_timeout", 0, 1);
      step();
   endtask

   initial begin
      int seen;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      in_valid = 1'b1;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_load", load, 0);
      chk("rst_enable_ks", enable_ks, 0);
      chk("rst_last_round", last_round, 0);
      chk("rst_mode_err", mode_err, 0);
      chk("rst_round_index", round_index, 0);
      chk("rst_round_step", round_step, 0);
      in_valid = 1'b0;
      step(2);
      rst_n = 1'b1;
      step();

      send(2'd0);
      wait_done();
      send(2'd1);
      wait_done();
      send(2'd2);
      wait_done();
      chk("mode_err_clean", mode_err, 0);
      send(2'd3);
      wait_done();
      chk("mode_err_set", mode_err, 1);
      send(2'd0);
      wait_done();
      chk("mode_err_sticky", mode_err, 1);

      out_ready = 1'b0;
      send(2'd0);
      for (int i = 0; i < 100 && !out_valid; i++) step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      key_mode  = 2'd0;
      q.push_back(mk(2'd0));
      #1 chk("b2b_load", load, 1);
      step();
      in_valid = 1'b0;
      chk("b2b_round_index", round_index, 0);
      chk("b2b_round_step", round_step, 0);
      chk("b2b_out_valid", out_valid, 0);
      wait_done();

      send(2'd0);
      for (int i = 0; i < 100 && !(round_index == 4'd4 && round_step == 2'd1); i++) step();
      chk("flush_point", int'(round_index == 4'd4 && round_step == 2'd1), 1);
      flush = 1'b1;
      #1 chk("flush_in_ready", in_ready, 0);
      chk("flush_out_valid", out_valid, 0);
      step();
      flush = 1'b0;
      q.delete();
      #1 chk("post_flush_in_ready", in_ready, 1);
      chk("post_flush_round_index", round_index, 0);
      seen = 0;
      for (int i = 0; i < 35; i++) begin
         seen += int'(out_valid);
         step();
      end
      chk("post_flush_no_out_valid", seen, 0);
      chk("flush_keeps_mode_err", mode_err, 1);

      send(2'd2);
      step(10);
      rst_n = 1'b0;
      #1 chk("midrst_round_index", round_index, 0);
      chk("midrst_round_step", round_step, 0);
      chk("midrst_enable_ks", enable_ks, 0);
      chk("midrst_last_round", last_round, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_mode_err", mode_err, 0);
      q.delete();
      step();
      rst_n = 1'b1;
      send(2'd0);
      wait_done();

      chk("sb_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
